mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle MIPS main-control FSM: the producer side of the ALU control interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the 4-bit ALU operation code, operand selects, register/memory/PC write enables and a request/ready handshake toward unified instruction/data memory.
- Sits between the instruction register and the datapath (ALU, register file, PC, memory port).

Parameters:
- RESET_ILLEGAL_STICKY, 1, 1 = illegal flag held until reset; 0 = cleared on the next FETCH

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero result (in0 == in1 during BEQ)
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request; held until mem_ready
- mem_we  output  1  write request (valid with mem_req)
- iord  output  1  0 = address from PC, 1 = ALU-out register
- ir_we  output  1  load IR from memory read data
- pc_we  output  1  unconditional PC write
- pc_src  output  2  0 = ALU result, 1 = ALU-out register, 2 = jump target, 3 = rs (jr)
- alu_src_a  output  1  0 = PC, 1 = rs
- alu_src_b  output  2  0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- alu_ctrl  output  4  ALU operation code
- reg_we  output  1  register-file write
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  output  2  0 = ALU-out register, 1 = memory data, 2 = PC (link)
- illegal  output  1  unsupported opcode/funct decoded

Behaviour:
- alu_ctrl encoding (package constants):
  - AND 4'b0000, OR 4'b0001, ADD 4'b0010, SLL 4'b0100, SRL 4'b0101, SUB 4'b0110, SLT 4'b0111
  - Never emit any other value.
- Reset (async, rst_n low):
  - state = FETCH.
  - All enables 0, all selects 0, alu_ctrl = ADD, illegal = 0.
  - Reset mid-instruction abandons it; no further writes occur.
- Outputs are Moore: registered state decoded combinationally. Enables are asserted only in the states listed below.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_ctrl = ADD, pc_src = 0.
  - ir_we and pc_we assert only in the cycle mem_ready = 1. Stay in FETCH otherwise.
  - On mem_ready, go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 3, alu_ctrl = ADD (branch target into ALU-out). Next state by opcode:
  - 0x00 -> RTEXE (funct 0x08 -> JR)
  - 0x23 / 0x2B -> MEMADR
  - 0x04 -> BEQ
  - 0x08 -> ADDIEXE
  - 0x02 / 0x03 -> JUMP
  - else -> ILLEGAL
  - R-type with unsupported funct -> ILLEGAL.
- RTEXE: alu_src_a = 1, alu_src_b = 0. alu_ctrl from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL
  - Next state: RTWB.
- RTWB: reg_we = 1, reg_dst = 1, mem_to_reg = 0. Next state: FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 2, ADD. Next state: MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req = 1, iord = 1, mem_we = 0. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_we = 1, reg_dst = 0, mem_to_reg = 1. Next state: FETCH.
- MEMWR: mem_req = 1, mem_we = 1, iord = 1. Wait for mem_ready, then go to FETCH.
- BEQ:
  - alu_src_a = 1, alu_src_b = 0, alu_ctrl = SUB, pc_src = 1.
  - pc_we = zero (combinational same-cycle gating).
  - Next state: FETCH.
- ADDIEXE: alu_src_a = 1, alu_src_b = 2, ADD. Next state: ADDIWB.
- ADDIWB: reg_we = 1, reg_dst = 0, mem_to_reg = 0. Next state: FETCH.
- JUMP:
  - pc_we = 1, pc_src = 2.
  - jal additionally: reg_we = 1, reg_dst = 2, mem_to_reg = 2 (PC already holds PC+4).
  - Next state: FETCH.
- JR: pc_we = 1, pc_src = 3. Next state: FETCH.
- ILLEGAL:
  - illegal = 1 (registered), no writes.
  - Next state: FETCH (PC already advanced).
  - Sticky per RESET_ILLEGAL_STICKY.
- Cycle counts with mem_ready = 1 on the first request cycle:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j/jal/jr 3.
  - Each extra wait cycle adds 1.
- mem_req never deasserts before mem_ready. mem_we is constant across a request.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - ALU op constants
  - opcode/funct constants
  - select-encoding constants for pc_src, alu_src_b, reg_dst, mem_to_reg
- One natural sub-module: mc_alu_dec, a combinational funct -> alu_ctrl / illegal-funct decode, reused by RTEXE.

Test Plan:
- Reset: hold rst_n = 0 mid-MEMRD, release -> state FETCH, all enables 0, alu_ctrl = 4'b0010, illegal = 0.
- add (op 0x00, funct 0x20), mem_ready immediate -> ir_we/pc_we cycle 1; alu_ctrl = 0010 cycle 3; reg_we = 1, reg_dst = 1 cycle 4; next mem_req cycle 5.
- lw (0x23) with mem_ready delayed 2 cycles in MEMRD -> mem_req/iord held 3 cycles, mem_we = 0; reg_we with mem_to_reg = 1 one cycle after ready; total 7 cycles.
- beq (0x04) twice: zero = 1 -> pc_we = 1, pc_src = 1, alu_ctrl = 0110; zero = 0 -> pc_we = 0; both return to FETCH after 3 cycles.
- Funct sweep 0x22/0x24/0x25/0x2A/0x00/0x02 -> alu_ctrl 0110/0000/0001/0111/0100/0101; funct 0x21 -> illegal = 1, no reg_we.
- jal (0x03) -> single cycle with pc_we = 1, pc_src = 2, reg_we = 1, reg_dst = 2, mem_to_reg = 2; jr (funct 0x08) -> pc_src = 3, no reg_we.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared types and encodings for the multicycle MIPS main control.
//            Holds the FSM state enum, the 4-bit ALU operation codes, the
//            opcode/funct values recognised by the decoder and the encodings
//            of every datapath select driven by mc_control.
// Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // Controller states, one per instruction phase.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_RTEXE   = 4'd2,
    S_RTWB    = 4'd3,
    S_MEMADR  = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWB   = 4'd6,
    S_MEMWR   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEXE = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  // ALU operation codes; these are the only values ever placed on alu_ctrl.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Primary opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // pc_src encodings.
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // alu_src_a encodings.
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  // alu_src_b encodings.
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  // reg_dst encodings.
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // mem_to_reg encodings.
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MEM    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_dec
// Purpose  : Combinational R-type funct decode. Maps the funct field to the
//            ALU operation code and flags functs with no ALU meaning.
// Ports    : funct_i     [5:0] in  - IR[5:0]
//            alu_ctrl_o  [3:0] out - ALU operation (ADD when unsupported)
//            illegal_o         out - funct is not an ALU R-type operation
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      FN_SLL:  alu_ctrl_o = ALU_SLL;
      FN_SRL:  alu_ctrl_o = ALU_SRL;
      // jr is recognised by the main decoder before this flag is consulted.
      default: illegal_o  = 1'b1;
    endcase
  end

endmodule : mc_alu_dec
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multicycle MIPS main-control FSM. Steps each instruction through
//            fetch/decode/execute/memory/writeback and drives the datapath
//            selects, write enables, ALU op code and memory handshake.
// Ports    : clk                in  - clock, rising edge
//            rst_n              in  - asynchronous active-low reset
//            opcode_i     [5:0] in  - IR[31:26], valid from DECODE onward
//            funct_i      [5:0] in  - IR[5:0]
//            zero_i             in  - ALU zero result (beq compare)
//            mem_ready_i        in  - memory completes request this cycle
//            mem_req_o          out - memory request, held until ready
//            mem_we_o           out - memory write request
//            iord_o             out - address select (0 PC, 1 ALU-out)
//            ir_we_o            out - instruction register load
//            pc_we_o            out - PC write
//            pc_src_o     [1:0] out - PC source select
//            alu_src_a_o        out - ALU A select (0 PC, 1 rs)
//            alu_src_b_o  [1:0] out - ALU B select
//            alu_ctrl_o   [3:0] out - ALU operation code
//            reg_we_o           out - register-file write
//            reg_dst_o    [1:0] out - destination register select
//            mem_to_reg_o [1:0] out - write-back data select
//            illegal_o          out - unsupported instruction seen
// Revision : 1.0 - initial release
// ============================================================================
module mc_control
  import mc_pkg::*;
#(
  parameter bit RESET_ILLEGAL_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_ctrl_o,
  output logic       reg_we_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       illegal_o
);

  state_e     state_q;
  state_e     state_d;
  logic       illegal_q;
  logic       illegal_d;

  logic [3:0] dec_alu_ctrl;
  logic       dec_illegal;

  mc_alu_dec u_alu_dec (
    .funct_i    (funct_i),
    .alu_ctrl_o (dec_alu_ctrl),
    .illegal_o  (dec_illegal)
  );

  // --------------------------------------------------------------------------
  // State and illegal-flag registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // The flag rises on entry to ILLEGAL so it is visible in that state. In
  // the non-sticky build it drops at the end of the first FETCH cycle after.
  always_comb begin
    illegal_d = illegal_q;
    if (state_d == S_ILLEGAL) begin
      illegal_d = 1'b1;
    end else if (!RESET_ILLEGAL_STICKY && (state_q == S_FETCH)) begin
      illegal_d = 1'b0;
    end
  end

  assign illegal_o = illegal_q;

  // --------------------------------------------------------------------------
  // Next state and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = PCSRC_ALU;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RT;
    alu_ctrl_o   = ALU_ADD;
    reg_we_o     = 1'b0;
    reg_dst_o    = REGDST_RT;
    mem_to_reg_o = M2R_ALUOUT;

    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        // IR load and PC+4 commit only in the cycle the read completes.
        ir_we_o     = mem_ready_i;
        pc_we_o     = mem_ready_i;
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is computed here speculatively into ALU-out.
        alu_src_b_o = SRCB_IMMSH2;
        case (opcode_i)
          OP_RTYPE: begin
            if (funct_i == FN_JR) begin
              state_d = S_JR;
            end else if (dec_illegal) begin
              state_d = S_ILLEGAL;
            end else begin
              state_d = S_RTEXE;
            end
          end
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEXE;
          OP_J, OP_JAL: state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end

      S_RTEXE: begin
        alu_src_a_o = SRCA_RS;
        alu_src_b_o = SRCB_RT;
        alu_ctrl_o  = dec_alu_ctrl;
        state_d     = S_RTWB;
      end

      S_RTWB: begin
        reg_we_o     = 1'b1;
        reg_dst_o    = REGDST_RD;
        mem_to_reg_o = M2R_ALUOUT;
        state_d      = S_FETCH;
      end

      S_MEMADR: begin
        alu_src_a_o = SRCA_RS;
        alu_src_b_o = SRCB_IMM;
        state_d     = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        reg_we_o     = 1'b1;
        reg_dst_o    = REGDST_RT;
        mem_to_reg_o = M2R_MEM;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
        end
      end

      S_BEQ: begin
        alu_src_a_o = SRCA_RS;
        alu_src_b_o = SRCB_RT;
        alu_ctrl_o  = ALU_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        // Same-cycle gating on the compare result.
        pc_we_o     = zero_i;
        state_d     = S_FETCH;
      end

      S_ADDIEXE: begin
        alu_src_a_o = SRCA_RS;
        alu_src_b_o = SRCB_IMM;
        state_d     = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_we_o     = 1'b1;
        reg_dst_o    = REGDST_RT;
        mem_to_reg_o = M2R_ALUOUT;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        pc_we_o  = 1'b1;
        pc_src_o = PCSRC_JUMP;
        // jal links through PC, which already holds PC+4 after FETCH.
        if (opcode_i == OP_JAL) begin
          reg_we_o     = 1'b1;
          reg_dst_o    = REGDST_RA;
          mem_to_reg_o = M2R_PC;
        end
        state_d = S_FETCH;
      end

      S_JR: begin
        pc_we_o  = 1'b1;
        pc_src_o = PCSRC_RS;
        state_d  = S_FETCH;
      end

      S_ILLEGAL: begin
        // No writes; PC was already advanced in FETCH.
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // While reset is held every enable and select sits at its idle value,
    // so an abandoned instruction cannot issue a request or a write.
    if (!rst_n) begin
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      iord_o       = 1'b0;
      ir_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      pc_src_o     = PCSRC_ALU;
      alu_src_a_o  = SRCA_PC;
      alu_src_b_o  = SRCB_RT;
      alu_ctrl_o   = ALU_ADD;
      reg_we_o     = 1'b0;
      reg_dst_o    = REGDST_RT;
      mem_to_reg_o = M2R_ALUOUT;
    end
  end

endmodule : mc_control
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Self-checking bench for mc_control. The stimulus process expands
//            each instruction into its expected per-cycle control vector and
//            queues it; a monitor pops and compares one vector every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

  localparam bit STICKY = 1'b1;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] m2r;
    logic       illegal;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o;
  logic [1:0] pc_src_o, alu_src_b_o, reg_dst_o, mem_to_reg_o;
  logic       alu_src_a_o, reg_we_o, illegal_o;
  logic [3:0] alu_ctrl_o;

  mc_control #(.RESET_ILLEGAL_STICKY(STICKY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode_i),
    .funct_i      (funct_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .iord_o       (iord_o),
    .ir_we_o      (ir_we_o),
    .pc_we_o      (pc_we_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .reg_we_o     (reg_we_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  out_t  expq[$];
  string tagq[$];
  int    checks   = 0;
  int    failures = 0;
  int    budget   = 1000000;
  bit    ill_model = 1'b0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      out_t  e;
      out_t  a;
      string t;
      e = expq.pop_front();
      t = tagq.pop_front();
      a = '{mem_req: mem_req_o, mem_we: mem_we_o, iord: iord_o, ir_we: ir_we_o,
            pc_we: pc_we_o, pc_src: pc_src_o, src_a: alu_src_a_o,
            src_b: alu_src_b_o, alu: alu_ctrl_o, reg_we: reg_we_o,
            reg_dst: reg_dst_o, m2r: mem_to_reg_o, illegal: illegal_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s @%0t: got req=%b we=%b iord=%b irwe=%b pcwe=%b pcsrc=%0d a=%b b=%0d alu=%b regwe=%b dst=%0d m2r=%0d ill=%b | expected req=%b we=%b iord=%b irwe=%b pcwe=%b pcsrc=%0d a=%b b=%0d alu=%b regwe=%b dst=%0d m2r=%0d ill=%b",
                 t, $time, a.mem_req, a.mem_we, a.iord, a.ir_we, a.pc_we, a.pc_src, a.src_a, a.src_b, a.alu, a.reg_we, a.reg_dst, a.m2r, a.illegal,
                 e.mem_req, e.mem_we, e.iord, e.ir_we, e.pc_we, e.pc_src, e.src_a, e.src_b, e.alu, e.reg_we, e.reg_dst, e.m2r, e.illegal);
      end
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic out_t base();
    out_t o;
    o = '0;
    o.alu = 4'b0010;
    o.illegal = ill_model;
    return o;
  endfunction

  // {supported, alu code} for an R-type funct (jr handled separately).
  function automatic logic [4:0] rfunct(input logic [5:0] f);
    case (f)
      6'h20: return {1'b1, 4'b0010};
      6'h22: return {1'b1, 4'b0110};
      6'h24: return {1'b1, 4'b0000};
      6'h25: return {1'b1, 4'b0001};
      6'h2A: return {1'b1, 4'b0111};
      6'h00: return {1'b1, 4'b0100};
      6'h02: return {1'b1, 4'b0101};
      default: return 5'b0;
    endcase
  endfunction

  // One clock cycle: drive ready, queue the expected vector, advance.
  task automatic cyc(input out_t e, input string tag, input bit rdy);
    if (budget <= 0) return;
    budget--;
    mem_ready_i = rdy;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    out_t e;
    rst_n = 1'b0;
    ill_model = 1'b0;
    for (int i = 0; i < n; i++) begin
      opcode_i = 6'($urandom);
      funct_i  = 6'($urandom);
      e = '0;
      e.alu = 4'b0010;
      cyc(e, "RESET", 1'($urandom));
    end
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fw, input int mw);
    out_t       e;
    logic [4:0] rf;
    // FETCH: opcode/funct are not yet meaningful, so scramble them.
    for (int i = 0; i < fw; i++) begin
      opcode_i = 6'($urandom);
      funct_i  = 6'($urandom);
      e = base(); e.mem_req = 1'b1; e.src_b = 2'd1;
      cyc(e, "FETCH_WAIT", 1'b0);
      if (!STICKY) ill_model = 1'b0;
    end
    opcode_i = 6'($urandom);
    funct_i  = 6'($urandom);
    e = base(); e.mem_req = 1'b1; e.src_b = 2'd1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    cyc(e, "FETCH", 1'b1);
    if (!STICKY) ill_model = 1'b0;

    opcode_i = op;
    funct_i  = fn;
    zero_i   = 1'($urandom);
    e = base(); e.src_b = 2'd3;
    cyc(e, "DECODE", 1'($urandom));

    rf = rfunct(fn);
    if (op == 6'h00 && fn == 6'h08) begin
      e = base(); e.pc_we = 1'b1; e.pc_src = 2'd3;
      cyc(e, "JR", 1'($urandom));
    end else if (op == 6'h00 && rf[4]) begin
      e = base(); e.src_a = 1'b1; e.src_b = 2'd0; e.alu = rf[3:0];
      cyc(e, "RTEXE", 1'($urandom));
      e = base(); e.reg_we = 1'b1; e.reg_dst = 2'd1; e.m2r = 2'd0;
      cyc(e, "RTWB", 1'($urandom));
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = base(); e.src_a = 1'b1; e.src_b = 2'd2;
      cyc(e, "MEMADR", 1'($urandom));
      for (int i = 0; i <= mw; i++) begin
        e = base(); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == 6'h2B);
        cyc(e, (op == 6'h23) ? "MEMRD" : "MEMWR", i == mw);
      end
      if (op == 6'h23) begin
        e = base(); e.reg_we = 1'b1; e.reg_dst = 2'd0; e.m2r = 2'd1;
        cyc(e, "MEMWB", 1'($urandom));
      end
    end else if (op == 6'h04) begin
      zero_i = z;
      e = base(); e.src_a = 1'b1; e.src_b = 2'd0; e.alu = 4'b0110;
      e.pc_src = 2'd1; e.pc_we = z;
      cyc(e, "BEQ", 1'($urandom));
    end else if (op == 6'h08) begin
      e = base(); e.src_a = 1'b1; e.src_b = 2'd2;
      cyc(e, "ADDIEXE", 1'($urandom));
      e = base(); e.reg_we = 1'b1; e.reg_dst = 2'd0; e.m2r = 2'd0;
      cyc(e, "ADDIWB", 1'($urandom));
    end else if (op == 6'h02 || op == 6'h03) begin
      e = base(); e.pc_we = 1'b1; e.pc_src = 2'd2;
      if (op == 6'h03) begin
        e.reg_we = 1'b1; e.reg_dst = 2'd2; e.m2r = 2'd2;
      end
      cyc(e, "JUMP", 1'($urandom));
    end else begin
      if (budget > 0) ill_model = 1'b1;
      e = base();
      cyc(e, "ILLEGAL", 1'($urandom));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] ops[8]  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03, 6'h00};
  logic [5:0] fns[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h21, 6'h03};

  initial begin
    rst_n = 1'b0;
    opcode_i = '0; funct_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(6'h00, 6'h20, 1'b0, 0, 0);          // add
    run_instr(6'h23, 6'h00, 1'b0, 0, 2);          // lw, two wait cycles
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);          // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);          // beq not taken
    for (int i = 0; i < 7; i++) run_instr(6'h00, fns[i], 1'b0, 0, 0);
    run_instr(6'h2B, 6'h11, 1'b0, 1, 1);          // sw with waits
    run_instr(6'h08, 6'h3F, 1'b0, 2, 0);          // addi
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);          // j
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);          // jal
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);          // jr

    // Reset in the middle of a load that is still waiting for memory.
    budget = 5;
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    budget = 1000000;
    do_reset(2);
    run_instr(6'h00, 6'h25, 1'b0, 0, 0);

    run_instr(6'h00, 6'h21, 1'b0, 0, 0);          // unsupported funct
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);          // unsupported opcode
    do_reset(1);

    for (int n = 0; n < 250; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
      if ($urandom_range(0, 19) == 0) begin
        budget = $urandom_range(1, 6);
        run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        budget = 1000000;
        do_reset($urandom_range(1, 2));
      end else begin
        run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked vectors, expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got no completion by %0t, expected finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mc_control
`default_nettype wire
